// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the EX-stage ALU A operand of the 16-bit pipeline.
// Define HAZARD_FWD_EN for forwarding with load-use stalls; otherwise a pure interlock.
module hazard_fwd_ctrl #(
  parameter int REG_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_src_a,
  input  logic              id_src_a_vld,
  input  logic [REG_W-1:0]  id_dst,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              flush,
  input  logic              hold,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              stall_out,
  output logic              bubble_out,
  output logic              alu_a_fowd_en,
  output logic [DATA_W-1:0] alu_a_fowd_data
);

  localparam logic [REG_W-1:0] NO_REG    = {REG_W{1'b1}};
  localparam logic [1:0]       SEL_NONE  = 2'd0;
  localparam logic [1:0]       SEL_EXMEM = 2'd1;
  localparam logic [1:0]       SEL_MEMWB = 2'd2;

  logic [REG_W-1:0] ex_dst_r;
  logic             ex_we_r;
  logic             ex_load_r;
  logic [REG_W-1:0] mem_dst_r;
  logic             mem_we_r;
  logic [1:0]       fwd_sel_r;

  logic       ex_match_s;
  logic       mem_match_s;
  logic       hazard_s;
  logic       stall_s;
  logic [1:0] fwd_sel_nxt_s;

  // Producer matching against the instructions now in EX and MEM
  always_comb begin
    ex_match_s  = id_src_a_vld & ex_we_r & (id_src_a == ex_dst_r) & (id_src_a != NO_REG);
    mem_match_s = id_src_a_vld & mem_we_r & (id_src_a == mem_dst_r) & (id_src_a != NO_REG);
  end

  // Hazard detection and forward-source choice; the youngest producer wins
  always_comb begin
    hazard_s      = 1'b0;
    fwd_sel_nxt_s = SEL_NONE;
`ifdef HAZARD_FWD_EN
    hazard_s = ex_match_s & ex_load_r;
    if (ex_match_s) begin
      fwd_sel_nxt_s = SEL_EXMEM;
    end else if (mem_match_s) begin
      fwd_sel_nxt_s = SEL_MEMWB;
    end else begin
      fwd_sel_nxt_s = SEL_NONE;
    end
`else
    hazard_s      = ex_match_s | mem_match_s;
    fwd_sel_nxt_s = SEL_NONE;
`endif
    // A frozen pipe or a killed instruction never needs a stall of its own
    stall_s = hazard_s & ~flush & ~hold;
  end

  assign stall_out  = stall_s;
  assign bubble_out = stall_s;

  // Tracking registers: advance unless the whole pipe is frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_dst_r  <= NO_REG;
      ex_we_r   <= 1'b0;
      ex_load_r <= 1'b0;
      mem_dst_r <= NO_REG;
      mem_we_r  <= 1'b0;
      fwd_sel_r <= SEL_NONE;
    end else if (!hold) begin
      mem_dst_r <= ex_dst_r;
      mem_we_r  <= ex_we_r;
      if (stall_s || flush) begin
        ex_dst_r  <= NO_REG;
        ex_we_r   <= 1'b0;
        ex_load_r <= 1'b0;
        fwd_sel_r <= SEL_NONE;
      end else begin
        ex_dst_r  <= id_dst;
        ex_we_r   <= id_we;
        ex_load_r <= id_load;
        fwd_sel_r <= fwd_sel_nxt_s;
      end
    end
  end

  // Forward mux driven from the decision registered at ID->EX
  always_comb begin
    alu_a_fowd_en = (fwd_sel_r != SEL_NONE);
    case (fwd_sel_r)
      SEL_EXMEM: alu_a_fowd_data = exmem_result;
      SEL_MEMWB: alu_a_fowd_data = memwb_result;
      default:   alu_a_fowd_data = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: an in-flight instruction queue model plus
// directed scenarios with hand-computed expectations for both build modes.
module tb_hazard_fwd_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_src_a;
  logic        id_src_a_vld;
  logic [3:0]  id_dst;
  logic        id_we;
  logic        id_load;
  logic        flush;
  logic        hold;
  logic [15:0] exmem_result;
  logic [15:0] memwb_result;
  logic        stall_out;
  logic        bubble_out;
  logic        alu_a_fowd_en;
  logic [15:0] alu_a_fowd_data;

  hazard_fwd_ctrl #(.REG_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_src_a(id_src_a), .id_src_a_vld(id_src_a_vld),
    .id_dst(id_dst), .id_we(id_we), .id_load(id_load),
    .flush(flush), .hold(hold),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .stall_out(stall_out), .bubble_out(bubble_out),
    .alu_a_fowd_en(alu_a_fowd_en), .alu_a_fowd_data(alu_a_fowd_data)
  );

  always #5 clk = ~clk;

  // In-flight instruction: what it writes and where its ALU A operand is forwarded from
  typedef struct packed {
    logic [3:0] dst;
    logic       we;
    logic       ld;
    logic [1:0] src;
  } instr_t;

  instr_t pipe[$];    // index 0 = EX, index 1 = MEM
  int     checks = 0;
  int     errors = 0;
  bit     chk_en = 1'b0;
  logic        exp_stall;
  logic        exp_en;
  logic [15:0] exp_data;
  logic [1:0]  next_src;
  int          last_stalls;

  function automatic instr_t nop_i();
    instr_t b;
    b.dst = 4'hF; b.we = 1'b0; b.ld = 1'b0; b.src = 2'd0;
    return b;
  endfunction

  function automatic logic [15:0] mv(input logic [15:0] f, input logic [15:0] il);
    return FWD ? f : il;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    pipe.push_back(nop_i());
    pipe.push_back(nop_i());
  endtask

  // Present an ID instruction and derive expectations from the in-flight queue
  task automatic issue(input logic [3:0] src, input logic v, input logic [3:0] dst,
                       input logic we, input logic ld, input logic fl, input logic hd);
    int prod;
    logic haz;
    id_src_a = src; id_src_a_vld = v; id_dst = dst; id_we = we; id_load = ld;
    flush = fl; hold = hd;
    prod = 0;
    for (int d = 0; d < 2; d++)
      if (prod == 0 && v && src != 4'hF && pipe[d].we && pipe[d].dst == src) prod = d + 1;
    haz = FWD ? (prod == 1 && pipe[0].ld) : (prod != 0);
    exp_stall = haz & ~fl & ~hd;
    next_src  = FWD ? 2'(prod) : 2'd0;
    exp_en    = (pipe[0].src != 2'd0);
    exp_data  = (pipe[0].src == 2'd1) ? exmem_result :
                (pipe[0].src == 2'd2) ? memwb_result : 16'h0000;
    #2;
  endtask

  task automatic tick();
    instr_t n;
    @(posedge clk);
    if (!hold) begin
      n = nop_i();
      if (!(exp_stall || flush)) begin
        n.dst = id_dst; n.we = id_we; n.ld = id_load; n.src = next_src;
      end
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
    #1;
  endtask

  // Issue an instruction, repeating while the model says it is stalled
  task automatic send(input logic [3:0] src, input logic v, input logic [3:0] dst,
                      input logic we, input logic ld);
    bit done = 1'b0;
    last_stalls = 0;
    for (int i = 0; i < 8; i++) begin
      issue(src, v, dst, we, ld, 1'b0, 1'b0);
      if (!exp_stall) begin
        tick();
        done = 1'b1;
        break;
      end
      last_stalls++;
      tick();
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: stall never released for src %h", src);
    end
  endtask

  task automatic nop();
    send(4'hF, 1'b0, 4'hF, 1'b0, 1'b0);
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_out", {15'd0, stall_out}, {15'd0, exp_stall});
      chk("bubble_out", {15'd0, bubble_out}, {15'd0, exp_stall});
      chk("fowd_en", {15'd0, alu_a_fowd_en}, {15'd0, exp_en});
      chk("fowd_data", alu_a_fowd_data, exp_data);
    end
  end

  initial begin
    rst = 1'b1;
    id_src_a = 4'hF; id_src_a_vld = 1'b0; id_dst = 4'hF; id_we = 1'b0; id_load = 1'b0;
    flush = 1'b0; hold = 1'b0; exmem_result = 16'h0000; memwb_result = 16'h0000;
    model_reset();
    #12;
    chk("rst_stall", {15'd0, stall_out}, 16'h0000);
    chk("rst_en", {15'd0, alu_a_fowd_en}, 16'h0000);
    chk("rst_data", alu_a_fowd_data, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    nop();

    // Back-to-back ALU dependency
    exmem_result = 16'h1234; memwb_result = 16'h5555;
    send(4'hF, 1'b0, 4'h1, 1'b1, 1'b0);
    send(4'h1, 1'b1, 4'h4, 1'b1, 1'b0);
    chk("alu_dep_stalls", 16'(last_stalls), mv(16'd0, 16'd2));
    issue(4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("alu_dep_en", {15'd0, alu_a_fowd_en}, mv(16'd1, 16'd0));
    chk("alu_dep_data", alu_a_fowd_data, mv(16'h1234, 16'h0000));
    tick();

    // Load-use
    exmem_result = 16'h0101; memwb_result = 16'hBEEF;
    send(4'hF, 1'b0, 4'h2, 1'b1, 1'b1);
    send(4'h2, 1'b1, 4'h0, 1'b1, 1'b0);
    chk("ld_use_stalls", 16'(last_stalls), mv(16'd1, 16'd2));
    issue(4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ld_use_en", {15'd0, alu_a_fowd_en}, mv(16'd1, 16'd0));
    chk("ld_use_data", alu_a_fowd_data, mv(16'hBEEF, 16'h0000));
    tick();

    // Double producer of R3: EX/MEM copy must win
    exmem_result = 16'hCAFE; memwb_result = 16'h1111;
    send(4'hF, 1'b0, 4'h3, 1'b1, 1'b0);
    send(4'hF, 1'b0, 4'h3, 1'b1, 1'b0);
    send(4'h3, 1'b1, 4'h8, 1'b1, 1'b0);
    chk("dbl_prod_stalls", 16'(last_stalls), mv(16'd0, 16'd2));
    issue(4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dbl_prod_data", alu_a_fowd_data, mv(16'hCAFE, 16'h0000));
    tick();

    // Single producer two ahead: MEM/WB source
    exmem_result = 16'h2222; memwb_result = 16'h6666;
    send(4'hF, 1'b0, 4'h6, 1'b1, 1'b0);
    nop();
    send(4'h6, 1'b1, 4'h9, 1'b1, 1'b0);
    chk("dist2_stalls", 16'(last_stalls), mv(16'd0, 16'd1));
    issue(4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dist2_data", alu_a_fowd_data, mv(16'h6666, 16'h0000));
    tick();

    // Flush during a load-use hazard
    send(4'hF, 1'b0, 4'h7, 1'b1, 1'b1);
    issue(4'h7, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("flush_stall", {15'd0, stall_out}, 16'h0000);
    tick();
    issue(4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_en", {15'd0, alu_a_fowd_en}, 16'h0000);
    tick();
    nop();

    // Hold for 3 cycles with a forward pending and a load-use hazard waiting in ID
    exmem_result = 16'h7777; memwb_result = 16'h3333;
    send(4'hF, 1'b0, 4'h1, 1'b1, 1'b0);
    send(4'h1, 1'b1, 4'h4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      memwb_result = 16'h3330 + 16'(i);
      issue(4'h4, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("hold_stall", {15'd0, stall_out}, 16'h0000);
      chk("hold_en", {15'd0, alu_a_fowd_en}, mv(16'd1, 16'd0));
      chk("hold_data", alu_a_fowd_data, mv(16'h7777, 16'h0000));
      tick();
    end
    memwb_result = 16'h4444;
    send(4'h4, 1'b1, 4'h5, 1'b1, 1'b0);
    chk("post_hold_stalls", 16'(last_stalls), mv(16'd1, 16'd2));
    issue(4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_hold_data", alu_a_fowd_data, mv(16'h4444, 16'h0000));
    tick();

    // Reset pulsed mid-stall
    exmem_result = 16'hAAAA; memwb_result = 16'hBBBB;
    send(4'hF, 1'b0, 4'h5, 1'b1, 1'b1);
    issue(4'h5, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_stall", {15'd0, stall_out}, 16'h0001);
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", {15'd0, stall_out}, 16'h0000);
    chk("mid_rst_bubble", {15'd0, bubble_out}, 16'h0000);
    chk("mid_rst_en", {15'd0, alu_a_fowd_en}, 16'h0000);
    chk("mid_rst_data", alu_a_fowd_data, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    issue(4'h5, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_stall", {15'd0, stall_out}, 16'h0000);
    tick();

    // Register id F never matches
    send(4'hF, 1'b1, 4'hF, 1'b1, 1'b1);
    issue(4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("noreg_stall", {15'd0, stall_out}, 16'h0000);
    tick();
    issue(4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("noreg_en", {15'd0, alu_a_fowd_en}, 16'h0000);
    tick();
    nop();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the ALU A operand path of the 16-bit five-stage CPU. It tracks destination registers of instructions in EX and MEM. It decides, at each ID→EX transition, whether the ALU A operand must be forwarded and from which stage. It drives the `ALU_A_FOWD_en`/`data_FOWD` inputs of the EX-stage ALU A operand mux, and raises stall/bubble requests for load-use hazards.

## Interface
Parameters:
- `REG_W`, 4, register id width (R0–R7, T, SP, IH, RA; 4'hF = no register)
- `DATA_W`, 16, datapath width

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `id_src_a`  in  REG_W  ALU A source register id of ID-stage instruction
- `id_src_a_vld`  in  1  ID instruction actually reads `id_src_a` through ALU A
- `id_dst`  in  REG_W  destination register id of ID-stage instruction
- `id_we`  in  1  ID instruction writes `id_dst`
- `id_load`  in  1  ID instruction is a memory load
- `flush`  in  1  ID instruction is killed (branch taken)
- `hold`  in  1  global pipeline freeze (memory/structural stall)
- `exmem_result`  in  DATA_W  ALU result latched in EX/MEM
- `memwb_result`  in  DATA_W  writeback value latched in MEM/WB
- `stall_out`  out  1  freeze PC and IF/ID
- `bubble_out`  out  1  load NOP into ID/EX
- `alu_a_fowd_en`  out  1  to ALU A mux forward enable
- `alu_a_fowd_data`  out  DATA_W  to ALU A mux forward data

## Operation
- Tracking regs: `ex_dst/ex_we/ex_load` (instruction now in EX), `mem_dst/mem_we` (now in MEM), `fwd_sel_q` (2 bits: 0 none, 1 EX/MEM, 2 MEM/WB).
- A match requires `id_src_a_vld`, stage `we=1`, equal ids, and id ≠ 4'hF.
- Hazard (forwarding build): `ex` match with `ex_load=1` (load-use).
- `stall_out = bubble_out = hazard & ~flush & ~hold`.
- On each clock with `hold=0`:
  - `mem_* <= ex_*`.
  - If `stall_out` or `flush`: `ex_*` loaded as bubble (`we=0`, `load=0`), `fwd_sel_q <= 0`.
  - Otherwise: `ex_* <= id_*`, and `fwd_sel_q <= 1` on `ex` match (non-load), else `2` on `mem` match, else `0`. EX match has priority over MEM match (youngest producer wins).
- `hold=1`: all tracking regs and `fwd_sel_q` keep their value. `stall_out`/`bubble_out` are forced 0, because `hold` already freezes the pipe.
- `alu_a_fowd_en = (fwd_sel_q != 0)`. `alu_a_fowd_data` = `exmem_result` for sel 1, `memwb_result` for sel 2, 0 otherwise.
- Register file writes through in the same cycle, so an ID read of a WB-stage destination needs no action.

## Timing
- Reset (async, immediate): all tracking regs cleared (`we=0`, `load=0`, dst=4'hF), `fwd_sel_q=0`. Outputs: `stall_out=0`, `bubble_out=0`, `alu_a_fowd_en=0`, `alu_a_fowd_data=0`.
- `stall_out`/`bubble_out` are combinational from ID inputs and tracking regs, valid in the same cycle.
- Forward decision is registered at the ID→EX edge. It is visible to the EX-stage mux for exactly the cycle that instruction occupies EX (longer if `hold`).
- Load-use costs exactly 1 bubble. The next cycle the load sits in MEM, the consumer re-evaluates, and `fwd_sel_q <= 2`.
- Reset deasserted mid-stream: the first instruction after reset sees no hazards.
- `flush` together with hazard: no stall; a bubble is inserted via the flush path.

## Configuration
- `HAZARD_FWD_EN` defined: behaviour as above.
- Not defined: pure interlock.
  - Hazard = `ex` match OR `mem` match, regardless of load.
  - Stall repeats each cycle until the producer reaches WB (up to 2 cycles).
  - `fwd_sel_q` is held at 0, so `alu_a_fowd_en` and `alu_a_fowd_data` stay 0.

## Test plan
- Back-to-back ALU dependency: ADD R1 then SUB using R1; `exmem_result=16'h1234` → no stall, consumer's EX cycle `alu_a_fowd_en=1`, `alu_a_fowd_data=16'h1234`. Without `HAZARD_FWD_EN`: 2 stall cycles, `alu_a_fowd_en=0`.
- Load-use: LW R2 then use R2 → `stall_out=bubble_out=1` for 1 cycle, then consumer in EX with `memwb_result=16'hBEEF` forwarded.
- Distance-2 dependency plus double producer: R3 written by both EX and MEM instructions → sel 1 (EX/MEM) chosen. Single producer two ahead → sel 2.
- `flush` asserted during a load-use hazard → `stall_out=0`, ID/EX bubble, `alu_a_fowd_en=0` next cycle.
- `hold=1` for 3 cycles with a pending forward → `alu_a_fowd_en` and data source stable all 3 cycles, `stall_out=0`, tracking unchanged.
- `rst` pulsed mid-stall → outputs 0 immediately; `id_src_a=4'hF` never matches even with `id_dst=4'hF`.
